// File: rtl/reaction_timer.sv
// reaction_timer: random-wait reaction timer that measures the press delay in ticks
// Ports: clk; rst_n (async, active-low); start_n, b (active-low keys, async to clk);
//   timecount (CW-bit result, 0 = no valid result); led (go light); done (valid result held);
//   foul (false start); busy (waiting or armed).
// Define REACTION_DEBOUNCE_EN to filter both keys with a DB_CYCLES stability window.
module reaction_timer #(
  parameter int CW         = 24,
  parameter int TICK_DIV   = 50000,
  parameter int DELAY_MIN  = 1000,
  parameter int DELAY_MASK = 2047,
  parameter int DB_CYCLES  = 250000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_n,
  input  logic          b,
  output logic [CW-1:0] timecount,
  output logic          led,
  output logic          done,
  output logic          foul,
  output logic          busy
);
  typedef enum logic [2:0] {s_idle, s_delay, s_armed, s_done, s_foul} state_t;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] tc_max = '1;
  state_t state, state_n;
  logic [CW-1:0] tc, tc_n;
  logic [31:0] dly, dly_n, load;
  logic [PW-1:0] ps;
  logic [15:0] lfsr;
  // bit 0 = start key, bit 1 = reaction key; all levels are active-low
  logic [1:0] sync1, lvl, cond, prev, ev;
  logic tick, ps_clr;
  assign ev = prev & ~cond;
  assign tick = ps == PW'(TICK_DIV - 1);
  assign load = 32'(DELAY_MIN) + (32'(lfsr) & 32'(DELAY_MASK));
  assign timecount = tc;
  assign led = state == s_armed;
  assign done = state == s_done;
  assign foul = state == s_foul;
  assign busy = state == s_delay || state == s_armed;
`ifdef REACTION_DEBOUNCE_EN
  localparam int DW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  logic [DW-1:0] cnt [2];
  // a key level is only accepted once it has differed from the held level for DB_CYCLES clks
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cond <= '1;
      cnt <= '{default: '0};
    end else
      for (int i = 0; i < 2; i++)
        if (lvl[i] == cond[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DB_CYCLES - 1)) begin
          cond[i] <= lvl[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + DW'(1);
`else
  assign cond = lvl;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= s_idle;
      tc <= '0;
      dly <= '0;
      ps <= '0;
      lfsr <= 16'hACE1;
      sync1 <= '1;
      lvl <= '1;
      prev <= '1;
    end else begin
      state <= state_n;
      tc <= tc_n;
      dly <= dly_n;
      ps <= (ps_clr || tick) ? '0 : ps + PW'(1);
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      sync1 <= {b, start_n};
      lvl <= sync1;
      prev <= cond;
    end
  // reaction key wins while timing; start key wins while idle or showing a result
  always_comb begin
    state_n = state;
    tc_n = tc;
    dly_n = dly;
    ps_clr = 1'b0;
    case (state)
      s_delay:
        if (ev[1]) begin
          state_n = s_foul;
          tc_n = '0;
        end else if (tick) begin
          if (dly == 32'd1) begin
            state_n = s_armed;
            tc_n = '0;
            ps_clr = 1'b1;
          end else dly_n = dly - 32'd1;
        end
      s_armed:
        if (ev[1]) begin
          state_n = s_done;
          tc_n = tc == '0 ? CW'(1) : tc;
        end else if (tick) begin
          tc_n = tc + CW'(1);
          state_n = tc == tc_max - CW'(1) ? s_done : s_armed;
        end
      default:
        if (ev[0]) begin
          state_n = s_delay;
          dly_n = load;
          tc_n = '0;
          ps_clr = 1'b1;
        end
    endcase
  end
endmodule
